// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the 16-bit ALU issue controller:
// opcodes, instruction field layout, FSM states, decode helpers.
package alu_issue_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int NREG   = 16;
  localparam int IMM_W  = 8;

  // Instruction field bit positions
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } instr_t;

  // Opcodes 0-7 all go through the ALU
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

  function automatic logic is_ldi(input logic [3:0] op);
    return (op == OP_LDI);
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 16x16 register file: two async read ports, one async debug port,
// one sync write port, async active-high reset to all zeros.
// Ports: clk, rst, we/waddr/wdata (write), ra/rb (operand reads),
//        dbg_addr/dbg_data (debug read).
// Macro ALU_ISSUE_ZERO_REG_EN: r0 reads 0 and ignores writes.
module alu_issue_regfile
  import alu_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] ra_addr,
  input  logic [REG_AW-1:0] rb_addr,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] rf_q [NREG];
  logic              we_eff;

`ifdef ALU_ISSUE_ZERO_REG_EN
  // r0 is never written, so it stays at its reset value of zero
  assign we_eff = we && (waddr != '0);
`else
  assign we_eff = we;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we_eff) begin
      rf_q[waddr] <= wdata;
    end
  end

  assign ra_data  = rf_q[ra_addr];
  assign rb_data  = rf_q[rb_addr];
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: accepts an instruction over
// valid/ready, reads operands, drives the external combinational
// ALU, then writes result and flags back two cycles per instruction.
// Ports: clk, rst (async high); instr_valid/instr_ready/instr;
//        alu_a/alu_b/alu_op out, alu_result/alu_z/c/n/o in;
//        flags_q {Z,C,N,O}, done, err pulses; dbg_addr/dbg_data.
// Macro ALU_ISSUE_ZERO_REG_EN: r0 hardwired to zero.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_n,
  input  logic              alu_o,
  output logic [3:0]        flags_q,
  output logic              done,
  output logic              err,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  instr_t ins;
  assign ins = instr_t'(instr);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic [3:0]        op_q;
  logic [REG_AW-1:0] rd_q;
  logic [IMM_W-1:0]  imm_q;
  logic [3:0]        flags_r_q, flags_r_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;

  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] ra_data, rb_data;

  alu_issue_regfile u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (rd_q),
    .wdata    (wdata),
    .ra_addr  (ins.rs1),
    .rb_addr  (ins.rs2),
    .dbg_addr (dbg_addr),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    we          = 1'b0;
    wdata       = alu_result;
    flags_r_d   = flags_r_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = IDLE;
        done_d  = 1'b1;
        unique case (1'b1)
          is_alu_op(op_q): begin
            we        = 1'b1;
            flags_r_d = {alu_z, alu_c, alu_n, alu_o};
          end
          is_ldi(op_q): begin
            we    = 1'b1;
            wdata = {{(DATA_W-IMM_W){1'b0}}, imm_q};
          end
          default: err_d = 1'b1;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      flags_r_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_r_q <= flags_r_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Operands are sampled at accept, so rd==rs hazards use old values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      rd_q  <= '0;
      imm_q <= '0;
    end else if (accept) begin
      a_q   <= ra_data;
      b_q   <= rb_data;
      op_q  <= ins.op;
      rd_q  <= ins.rd;
      imm_q <= {ins.rs1, ins.rs2};
    end
  end

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_op  = op_q;
  assign flags_q = flags_r_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with an ALU
// model on the DUT's ALU port and an array-based reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_z, alu_c, alu_n, alu_o;
  logic [3:0]  flags_q;
  logic        done, err;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

`ifdef ALU_ISSUE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_z       (alu_z),
    .alu_c       (alu_c),
    .alu_n       (alu_n),
    .alu_o       (alu_o),
    .flags_q     (flags_q),
    .done        (done),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural 16-bit ALU: returns {result, Z, C, N, O}
  function automatic logic [19:0] alu_f(input logic [3:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic        c, o;
    c = 1'b0;
    o = 1'b0;
    case (op)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0];
        c = w[16];
        o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'd1: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[15:0];
        c = w[16];
        o = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = a << 1; c = a[15]; end
      4'd7: begin r = a >> 1; c = a[0]; end
      default: r = 16'hDEAD;
    endcase
    return {r, (r == 16'h0), c, r[15], o};
  endfunction

  assign {alu_result, alu_z, alu_c, alu_n, alu_o} =
    alu_f(alu_op, alu_a, alu_b);

  // Reference model state
  logic [15:0] m_rf [16];
  logic [3:0]  m_fl;
  int          prev_t0 = 0;
  bit          prev_keep = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
    m_fl = 4'h0;
  endtask

  task automatic model_wr(input logic [3:0] rd, input logic [15:0] v);
    if (!(ZR && rd == 4'd0)) m_rf[rd] = v;
  endtask

  // Issue one instruction and check both cycles of its life.
  // keep=1 leaves instr_valid high for back-to-back issue.
  task automatic run(input logic [15:0] ins, input bit keep);
    logic [3:0]  op, rd, rs1, rs2;
    logic [19:0] r;
    int          t0;
    {op, rd, rs1, rs2} = ins;
    @(negedge clk);
    chk("ready_idle", {31'b0, instr_ready}, 1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    if (!keep) instr_valid = 1'b0;
    if (prev_keep) chk("b2b_gap", t0 - prev_t0, 2);
    prev_t0 = t0;
    prev_keep = keep;
    chk("ready_exec", {31'b0, instr_ready}, 0);
    chk("alu_a", {16'b0, alu_a}, {16'b0, m_rf[rs1]});
    chk("alu_b", {16'b0, alu_b}, {16'b0, m_rf[rs2]});
    chk("alu_op", {28'b0, alu_op}, {28'b0, op});
    chk("done_exec", {31'b0, done}, 0);
    if (op < 4'd8) begin
      r = alu_f(op, m_rf[rs1], m_rf[rs2]);
      model_wr(rd, r[19:4]);
      m_fl = r[3:0];
    end else if (op == 4'd8) begin
      model_wr(rd, {8'h00, rs1, rs2});
    end
    @(posedge clk);
    #1;
    chk("done", {31'b0, done}, 1);
    chk("err", {31'b0, err}, {31'b0, (op > 4'd8)});
    chk("flags", {28'b0, flags_q}, {28'b0, m_fl});
    chk("ready_done", {31'b0, instr_ready}, 1);
    dbg_addr = rd;
    #1;
    chk("wb", {16'b0, dbg_data}, {16'b0, m_rf[rd]});
  endtask

  initial begin
    logic [3:0] rop;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0;
    dbg_addr = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", {16'b0, alu_a}, 0);
    chk("rst_b", {16'b0, alu_b}, 0);
    chk("rst_op", {28'b0, alu_op}, 0);
    chk("rst_flags", {28'b0, flags_q}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_dbg", {16'b0, dbg_data}, 0);
    @(negedge clk);
    rst = 1'b0;

    // LDI r1,#05; LDI r2,#03; ADD r3,r1,r2
    run(16'h8105, 1'b0);
    run(16'h8203, 1'b0);
    run(16'h0312, 1'b0);
    dbg_addr = 4'd3;
    #1;
    chk("t1_r3", {16'b0, dbg_data}, 32'h0008);
    chk("t1_z", {31'b0, flags_q[3]}, 0);

    // SUB r4,r2,r2 sets Z; LDI leaves flags alone
    run(16'h1422, 1'b0);
    chk("t2_z", {31'b0, flags_q[3]}, 1);
    run(16'h86AA, 1'b0);
    chk("t2_ldi_z", {28'b0, flags_q}, 32'h8);

    // Illegal opcode targeting r1
    run(16'h9123, 1'b0);
    dbg_addr = 4'd1;
    #1;
    chk("t3_r1", {16'b0, dbg_data}, 32'h0005);

    // Back-to-back with valid held high
    run(16'h0712, 1'b1);
    run(16'h4871, 1'b1);
    run(16'h2937, 1'b1);
    run(16'h8A5C, 1'b1);
    instr_valid = 1'b0;
    prev_keep = 1'b0;

    // Reset during EXEC of ADD r5,r1,r2
    @(negedge clk);
    instr = 16'h0512;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("t5_no_done", {31'b0, done}, 0);
    end
    dbg_addr = 4'd5;
    #1;
    chk("t5_r5", {16'b0, dbg_data}, 0);
    chk("t5_flags", {28'b0, flags_q}, 0);
    run(16'h8542, 1'b0);

    // LDI r0,#FF
    run(16'h80FF, 1'b0);
    dbg_addr = 4'd0;
    #1;
    chk("t6_r0", {16'b0, dbg_data}, ZR ? 32'h0 : 32'h00FF);

    // Random traffic
    for (int k = 0; k < 80; k++) begin
      rop = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rop = 4'd8;
      run({rop, 12'($urandom)}, bit'($urandom_range(0, 1)));
    end
    instr_valid = 1'b0;
    prev_keep = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk("final_rf", {16'b0, dbg_data}, {16'b0, m_rf[i]});
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  // Watchdog keeps the run bounded if the handshake ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
